// File: rtl/tlk2711_pkg.sv
// tlk2711_pkg: mode/state encodings, TLK2711 word constants and the CRC16-CCITT word update.
package tlk2711_pkg;
  typedef enum logic [1:0] {M_NORM, M_LOOP, M_KCODE, M_PRBS} mode_t;
  typedef enum logic [2:0] {T_IDLE, T_NORM, T_LOOP, T_KCODE, T_PRBS} top_t;
  typedef enum logic [2:0] {PH_COMMA, PH_SOF, PH_DATA, PH_CRC, PH_EOF, PH_GAP} phase_t;
  localparam logic [7:0] K28_5 = 8'hBC, D5_6 = 8'hC5, D11_5 = 8'hAB, D21_5 = 8'hB5;
  localparam logic [15:0] W_COMMA = {K28_5, D5_6}, W_SOF = {K28_5, D11_5}, W_EOF = {K28_5, D21_5};
  localparam logic [15:0] CRC_POLY = 16'h1021, CRC_INIT = 16'hFFFF;
  typedef struct packed {
    logic [15:0] txd;
    logic tkmsb, loopen, prbsen, enable, lckrefn, busy, stop_ack;
  } pins_t;
  function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] data);
    logic [15:0] c;
    c = crc ^ data;
    for (int i = 0; i < 16; i++) c = c[15] ? {c[14:0], 1'b0} ^ CRC_POLY : {c[14:0], 1'b0};
    return c;
  endfunction
endpackage

// File: rtl/tlk2711_crc16.sv
// tlk2711_crc16: CRC16-CCITT over 16-bit words, MSB first, with synchronous clear to the init value.
module tlk2711_crc16
  import tlk2711_pkg::*;
(
  input  logic        tx_clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [15:0] i_data,
  output logic [15:0] o_crc
);
  logic [15:0] crc_q, crc_d;
  always_comb crc_d = i_clr ? CRC_INIT : i_en ? crc16_word(crc_q, i_data) : crc_q;
  always_ff @(posedge tx_clk or negedge rst_n)
    if (!rst_n) crc_q <= CRC_INIT;
    else crc_q <= crc_d;
  assign o_crc = crc_q;
endmodule

// File: rtl/tlk2711_tx_framer.sv
// tlk2711_tx_framer: TLK2711 TX framer with NORM/LOOP/KCODE/PRBS modes and graceful stop.
// Define TLK_TX_CRC_EN to append a CRC16-CCITT word after the payload of each packet.
module tlk2711_tx_framer
  import tlk2711_pkg::*;
#(
  parameter int PKT_WORDS = 32,
  parameter int NUM_COMMA = 2,
  parameter int IDLE_GAP  = 4,
  parameter int CNT_W     = 16
) (
  input  logic             tx_clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic             i_stop,
  output logic             o_stop_ack,
  input  logic [15:0]      i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [15:0]      o_txd,
  output logic             o_tkmsb,
  output logic             o_tklsb,
  output logic             o_loopen,
  output logic             o_prbsen,
  output logic             o_enable,
  output logic             o_lckrefn,
  output logic             o_testen,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_pkt_cnt
);
  top_t mode_q, mode_d;
  phase_t phase_q, phase_d;
  pins_t pins_q, pins_d;
  logic [15:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic stop_lat_q, stop_lat_d, start_p_q, stop_p_q;
  assign o_ready = mode_q == T_NORM && phase_q == PH_DATA;
`ifdef TLK_TX_CRC_EN
  localparam phase_t PH_LAST = PH_CRC;
  logic [15:0] crc;
  tlk2711_crc16 u_crc (
    .tx_clk (tx_clk),
    .rst_n  (rst_n),
    .i_clr  (mode_q == T_NORM && phase_q == PH_SOF),
    .i_en   (o_ready & i_valid),
    .i_data (i_data),
    .o_crc  (crc)
  );
`else
  localparam phase_t PH_LAST = PH_EOF;
`endif
  always_comb begin
    mode_d = mode_q;
    phase_d = phase_q;
    cnt_d = cnt_q;
    pkt_d = pkt_q;
    stop_lat_d = stop_lat_q | i_stop;
    pins_d = '0;
    pins_d.lckrefn = 1'b1;
    pins_d.enable = mode_q != T_IDLE;
    pins_d.busy = mode_q != T_IDLE;
    case (mode_q)
      T_IDLE: begin
        stop_lat_d = 1'b0;
        pins_d.stop_ack = i_stop & ~stop_p_q;
        if (i_start & ~start_p_q) begin
          mode_d = i_mode == M_LOOP ? T_LOOP : i_mode == M_KCODE ? T_KCODE : i_mode == M_PRBS ? T_PRBS : T_NORM;
          phase_d = PH_COMMA;
          cnt_d = '0;
        end
      end
      T_NORM: begin
        pins_d.txd = W_COMMA;
        pins_d.tkmsb = 1'b1;
        cnt_d = cnt_q + 16'd1;
        case (phase_q)
          PH_COMMA: if (cnt_q == 16'(NUM_COMMA - 1)) begin
            phase_d = PH_SOF;
            cnt_d = '0;
          end
          PH_SOF: begin
            pins_d.txd = W_SOF;
            phase_d = PH_DATA;
            cnt_d = '0;
          end
          PH_DATA: begin
            // an underrun emits a comma fill and holds the word count
            cnt_d = cnt_q + 16'(i_valid);
            pins_d.txd = i_valid ? i_data : W_COMMA;
            pins_d.tkmsb = ~i_valid;
            if (i_valid && cnt_q == 16'(PKT_WORDS - 1)) begin
              phase_d = PH_LAST;
              cnt_d = '0;
            end
          end
`ifdef TLK_TX_CRC_EN
          PH_CRC: begin
            pins_d.txd = crc;
            pins_d.tkmsb = 1'b0;
            phase_d = PH_EOF;
          end
`endif
          PH_EOF: begin
            pins_d.txd = W_EOF;
            pkt_d = pkt_q + CNT_W'(1);
            cnt_d = '0;
            pins_d.stop_ack = stop_lat_d;
            mode_d = stop_lat_d ? T_IDLE : T_NORM;
            phase_d = IDLE_GAP == 0 ? PH_COMMA : PH_GAP;
          end
          default: if (cnt_q == 16'(IDLE_GAP - 1)) begin
            phase_d = PH_COMMA;
            cnt_d = '0;
          end
        endcase
      end
      T_LOOP, T_KCODE, T_PRBS: begin
        pins_d.txd = mode_q == T_PRBS ? 16'h0000 : W_COMMA;
        pins_d.tkmsb = mode_q != T_PRBS;
        pins_d.loopen = mode_q == T_LOOP;
        pins_d.prbsen = mode_q == T_PRBS;
        pins_d.stop_ack = i_stop;
        mode_d = i_stop ? T_IDLE : mode_q;
      end
      default: mode_d = T_IDLE;
    endcase
  end
  always_ff @(posedge tx_clk or negedge rst_n)
    if (!rst_n) begin
      mode_q <= T_IDLE;
      phase_q <= PH_COMMA;
      cnt_q <= '0;
      pkt_q <= '0;
      stop_lat_q <= 1'b0;
      start_p_q <= 1'b0;
      stop_p_q <= 1'b0;
      pins_q <= '0;
    end else begin
      mode_q <= mode_d;
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      pkt_q <= pkt_d;
      stop_lat_q <= stop_lat_d;
      start_p_q <= i_start;
      stop_p_q <= i_stop;
      pins_q <= pins_d;
    end
  assign o_txd = pins_q.txd;
  assign o_tkmsb = pins_q.tkmsb;
  assign o_tklsb = 1'b0;
  assign o_loopen = pins_q.loopen;
  assign o_prbsen = pins_q.prbsen;
  assign o_enable = pins_q.enable;
  assign o_lckrefn = pins_q.lckrefn;
  assign o_testen = 1'b0;
  assign o_busy = pins_q.busy;
  assign o_stop_ack = pins_q.stop_ack;
  assign o_pkt_cnt = pkt_q;
endmodule

// File: tb/tb_tlk2711_tx_framer.sv
// tb_tlk2711_tx_framer: directed and randomized bench for tlk2711_tx_framer against a
// packet-position model (one position counter per frame, stalled by underruns).
`timescale 1ns/1ps
module tb_tlk2711_tx_framer;
  localparam int PW = 4, NC = 2, GAP = 4;
`ifdef TLK_TX_CRC_EN
  localparam int CW = 1;
`else
  localparam int CW = 0;
`endif
  localparam int EOFP = NC + 1 + PW + CW, FRAME = EOFP + 1 + GAP;
  logic tx_clk = 0, rst_n = 0, i_start = 0, i_stop = 0, i_valid = 0;
  logic [1:0] i_mode = 0;
  logic [15:0] i_data = 0;
  logic o_stop_ack, o_ready, o_tkmsb, o_tklsb, o_loopen, o_prbsen, o_enable, o_lckrefn, o_testen, o_busy;
  logic [15:0] o_txd, o_pkt_cnt;

  tlk2711_tx_framer #(.PKT_WORDS(PW), .NUM_COMMA(NC), .IDLE_GAP(GAP), .CNT_W(16)) dut (
    .tx_clk(tx_clk), .rst_n(rst_n), .i_start(i_start), .i_mode(i_mode), .i_stop(i_stop),
    .o_stop_ack(o_stop_ack), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_txd(o_txd), .o_tkmsb(o_tkmsb), .o_tklsb(o_tklsb), .o_loopen(o_loopen), .o_prbsen(o_prbsen),
    .o_enable(o_enable), .o_lckrefn(o_lckrefn), .o_testen(o_testen), .o_busy(o_busy),
    .o_pkt_cnt(o_pkt_cnt)
  );

  always #5 tx_clk = ~tx_clk;

  int nchk = 0, nfail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    c = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction
  function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [15:0] w);
    return crc_byte(crc_byte(c, w[15:8]), w[7:0]);
  endfunction

  // model: mode 0 idle,1 norm,2 loop,3 kcode,4 prbs; m_pos walks one frame
  int m_mode = 0, m_pos = 0, m_pkts = 0;
  bit m_stop = 0, m_sp = 0, m_tp = 0;
  logic [15:0] m_crc = 16'hFFFF, e_txd = 0;
  logic e_tk = 0, e_loop = 0, e_prbs = 0, e_en = 0, e_lck = 0, e_busy = 0, e_ack = 0;

  always @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pos = 0; m_pkts = 0; m_stop = 0; m_sp = 0; m_tp = 0;
      e_txd = 0; e_tk = 0; e_loop = 0; e_prbs = 0; e_en = 0; e_lck = 0; e_busy = 0; e_ack = 0;
    end else begin
      bit in_data;
      e_txd = 0; e_tk = 0; e_loop = 0; e_prbs = 0; e_ack = 0; e_lck = 1;
      e_en = m_mode != 0;
      e_busy = m_mode != 0;
      if (m_mode == 0) begin
        e_ack = i_stop && !m_sp;
        if (i_start && !m_tp) begin m_mode = int'(i_mode) + 1; m_pos = 0; m_stop = 0; end
      end else if (m_mode == 1) begin
        m_stop = m_stop | i_stop;
        in_data = m_pos > NC && m_pos <= NC + PW;
        e_txd = 16'hBCC5;
        e_tk = 1;
        if (m_pos == NC) begin
          e_txd = 16'hBCAB;
          m_crc = 16'hFFFF;
        end else if (in_data && i_valid) begin
          e_txd = i_data;
          e_tk = 0;
          m_crc = crc_word(m_crc, i_data);
        end else if (CW == 1 && m_pos == NC + PW + 1) begin
          e_txd = m_crc;
          e_tk = 0;
        end else if (m_pos == EOFP) begin
          e_txd = 16'hBCB5;
          m_pkts++;
          if (m_stop) begin m_mode = 0; e_ack = 1; end
        end
        if (!(in_data && !i_valid)) m_pos = (m_pos + 1) % FRAME;
      end else begin
        e_txd = m_mode == 4 ? 16'h0000 : 16'hBCC5;
        e_tk = m_mode != 4;
        e_loop = m_mode == 2;
        e_prbs = m_mode == 4;
        if (i_stop) begin m_mode = 0; e_ack = 1; end
      end
      m_sp = i_stop;
      m_tp = i_start;
    end
  end

  bit chk_on = 0;
  always @(negedge tx_clk) if (chk_on) begin
    chk("txd", o_txd, e_txd);
    chk("tkmsb", o_tkmsb, e_tk);
    chk("tklsb", o_tklsb, 0);
    chk("loopen", o_loopen, e_loop);
    chk("prbsen", o_prbsen, e_prbs);
    chk("enable", o_enable, e_en);
    chk("lckrefn", o_lckrefn, e_lck);
    chk("testen", o_testen, 0);
    chk("busy", o_busy, e_busy);
    chk("stop_ack", o_stop_ack, e_ack);
    chk("ready", o_ready, m_mode == 1 && m_pos > NC && m_pos <= NC + PW);
    chk("pkt_cnt", o_pkt_cnt, m_pkts[15:0]);
  end

  int dseq = 0;
  bit rnd = 0;
  task automatic cyc();
    logic acc;
    acc = o_ready & i_valid;
    @(negedge tx_clk);
    #1;
    if (acc) begin
      dseq++;
      i_data = rnd ? 16'($urandom) : 16'(dseq);
    end
  endtask
  task automatic wait_ready(input string name);
    int n = 0;
    while (!o_ready && n < 100) begin cyc(); n++; end
    chk(name, n < 100, 1);
  endtask

  initial begin
    logic [15:0] seq[$];
    logic [15:0] c;
    int n;
    #100000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] seq[$];
    logic [15:0] c;
    int n;
    c = 16'hFFFF;
    for (int i = 1; i <= 9; i++) c = crc_byte(c, 8'(8'h30 + i));
    chk("crc_model_123456789", c, 16'h29B1);
    repeat (3) cyc();
    chk("rst_txd", o_txd, 0);
    chk("rst_lckrefn", o_lckrefn, 0);
    chk("rst_enable", o_enable, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_pkt_cnt", o_pkt_cnt, 0);
    chk("rst_ready", o_ready, 0);
    rst_n = 1;
    chk_on = 1;
    cyc();
    chk("idle_lckrefn", o_lckrefn, 1);
    // first NORM packet with data 1..4 and no underrun
    dseq = 1; i_data = 1; i_valid = 1; i_mode = 0; i_start = 1;
    cyc();
    i_start = 0;
    seq = '{16'hBCC5, 16'hBCC5, 16'hBCAB, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    c = 16'hFFFF;
    for (int i = 1; i <= 4; i++) c = crc_word(c, 16'(i));
    if (CW == 1) seq.push_back(c);
    seq.push_back(16'hBCB5);
    repeat (GAP) seq.push_back(16'hBCC5);
    foreach (seq[k]) begin
      cyc();
      chk($sformatf("pkt1_w%0d", k), o_txd, seq[k]);
    end
    chk("pkt1_cnt", o_pkt_cnt, 1);
    // second packet: three-cycle underrun after the second payload word
    wait_ready("wait_pkt2_data");
    seq = '{16'h0005, 16'h0006, 16'hBCC5, 16'hBCC5, 16'hBCC5, 16'h0007, 16'h0008};
    c = 16'hFFFF;
    for (int i = 5; i <= 8; i++) c = crc_word(c, 16'(i));
    if (CW == 1) seq.push_back(c);
    seq.push_back(16'hBCB5);
    foreach (seq[k]) begin
      i_valid = !(k >= 2 && k < 5);
      cyc();
      chk($sformatf("pkt2_w%0d", k), o_txd, seq[k]);
      if (k == 3) chk("pkt2_fill_tkmsb", o_tkmsb, 1);
    end
    i_valid = 1;
    chk("pkt2_cnt", o_pkt_cnt, 2);
    // third packet: stop raised while the second comma is being sent
    repeat (GAP + 1) cyc();
    chk("pkt3_comma1", o_txd, 16'hBCC5);
    i_stop = 1;
    cyc();
    i_stop = 0;
    n = 0;
    while (!o_stop_ack && n < 20) begin cyc(); n++; end
    chk("stop_latency", n, 6 + CW);
    chk("stop_eof", o_txd, 16'hBCB5);
    chk("stop_cnt", o_pkt_cnt, 3);
    cyc();
    chk("stop_enable", o_enable, 0);
    chk("stop_busy", o_busy, 0);
    chk("stop_no_gap", o_txd, 0);
    chk("stop_ack_once", o_stop_ack, 0);
    // stop request while idle
    i_stop = 1;
    cyc();
    chk("idle_ack", o_stop_ack, 1);
    cyc();
    chk("idle_ack_pulse", o_stop_ack, 0);
    i_stop = 0;
    cyc();
    // LOOP mode
    i_mode = 1; i_start = 1;
    cyc();
    i_start = 0;
    repeat (3) cyc();
    chk("loop_loopen", o_loopen, 1);
    chk("loop_txd", o_txd, 16'hBCC5);
    chk("loop_enable", o_enable, 1);
    i_stop = 1;
    cyc();
    chk("loop_ack", o_stop_ack, 1);
    i_stop = 0;
    cyc();
    chk("loop_ack_pulse", o_stop_ack, 0);
    chk("loop_off", o_loopen, 0);
    // asynchronous reset in the middle of DATA
    i_mode = 0; i_start = 1;
    cyc();
    i_start = 0;
    wait_ready("wait_rst_data");
    repeat (2) cyc();
    rst_n = 0;
    #1;
    chk("arst_txd", o_txd, 0);
    chk("arst_enable", o_enable, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_lckrefn", o_lckrefn, 0);
    chk("arst_ready", o_ready, 0);
    chk("arst_pkt_cnt", o_pkt_cnt, 0);
    cyc();
    rst_n = 1;
    cyc();
    i_start = 1;
    cyc();
    i_start = 0;
    seq = '{16'hBCC5, 16'hBCC5, 16'hBCAB};
    foreach (seq[k]) begin
      cyc();
      chk($sformatf("restart_w%0d", k), o_txd, seq[k]);
    end
    // randomized traffic across all modes
    rnd = 1;
    for (int k = 0; k < 4000; k++) begin
      i_valid = $urandom_range(0, 9) < 7;
      i_start = $urandom_range(0, 39) == 0;
      i_mode = 2'($urandom);
      i_stop = $urandom_range(0, 59) == 0;
      cyc();
    end
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
